// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared switch-conditioning constants and counter width helper
package io_pkg;

    localparam int NUM_SW_DEF          = 2;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

    // Counter only has to reach DEBOUNCE_CYCLES-1, so clog2 of the window is enough.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles);
    endfunction

    localparam int DB_CNT_W_DEF = cnt_width(DEBOUNCE_CYCLES_DEF);

    typedef logic [DB_CNT_W_DEF-1:0] db_count_t;

endpackage

// File: rtl/sw_debounce_cell.sv
// rtl/sw_debounce_cell.sv - one-switch synchronizer/debouncer; edge pulses and sticky flag under SWITCH_EDGE_EN
module sw_debounce_cell
    import io_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic sw_raw,
    input  logic clr_changed,
    output logic sw_stable,
    output logic sw_rise,
    output logic sw_fall,
    output logic sw_changed
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic [CNT_W-1:0]       count;
    logic                   synced;
    logic                   accept;

    assign synced = sync_ff[SYNC_STAGES-1];
    assign accept = (synced != sw_stable) && (count == CNT_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], sw_raw};
        end
    end

    // Any cycle where synced agrees with the stable level restarts the window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            sw_stable <= 1'b0;
        end else if (synced == sw_stable) begin
            count <= '0;
        end else if (accept) begin
            count     <= '0;
            sw_stable <= synced;
        end else begin
            count <= count + 1'b1;
        end
    end

`ifdef SWITCH_EDGE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_rise    <= 1'b0;
            sw_fall    <= 1'b0;
            sw_changed <= 1'b0;
        end else begin
            sw_rise <= accept & synced;
            sw_fall <= accept & ~synced;
            // A new transition outranks a clear on the same edge.
            if (accept) begin
                sw_changed <= 1'b1;
            end else if (clr_changed) begin
                sw_changed <= 1'b0;
            end
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr_changed;
    assign sw_rise    = 1'b0;
    assign sw_fall    = 1'b0;
    assign sw_changed = 1'b0;
`endif

endmodule

// File: rtl/io_switch_conditioner.sv
// rtl/io_switch_conditioner.sv - NUM_SW debounced switch lanes for the data-memory IO device (SWITCH_EDGE_EN enables edge/flag outputs)
module io_switch_conditioner
    import io_pkg::*;
#(
    parameter int NUM_SW          = NUM_SW_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw_raw,
    input  logic [NUM_SW-1:0] clr_changed,
    output logic [NUM_SW-1:0] sw_stable,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic [NUM_SW-1:0] sw_changed
);

    for (genvar i = 0; i < NUM_SW; i++) begin : g_cell
        sw_debounce_cell #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clock      (clock),
            .reset      (reset),
            .sw_raw     (sw_raw[i]),
            .clr_changed(clr_changed[i]),
            .sw_stable  (sw_stable[i]),
            .sw_rise    (sw_rise[i]),
            .sw_fall    (sw_fall[i]),
            .sw_changed (sw_changed[i])
        );
    end

endmodule

// File: tb/tb_io_switch_conditioner.sv
// tb/tb_io_switch_conditioner.sv - scoreboard bench for io_switch_conditioner with a sample-history reference model
module tb_io_switch_conditioner;

    localparam int NSW = 2;
    localparam int S   = 2;
    localparam int D   = 16;
`ifdef SWITCH_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [NSW-1:0] sw_raw = '0;
    logic [NSW-1:0] clr_changed = '0;
    logic [NSW-1:0] sw_stable, sw_rise, sw_fall, sw_changed;

    always #5 clock = ~clock;

    io_switch_conditioner #(
        .NUM_SW(NSW), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .clr_changed(clr_changed),
        .sw_stable  (sw_stable),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed)
    );

    typedef struct packed {
        logic [NSW-1:0] stable;
        logic [NSW-1:0] rise;
        logic [NSW-1:0] fall;
        logic [NSW-1:0] changed;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference: a raw level reaches the checker S edges after capture, and the
    // stable level flips once the last D checked samples all disagree with it.
    bit             pipe_q[NSW][$];
    bit             hist_q[NSW][$];
    logic [NSW-1:0] m_stable, m_rise, m_fall, m_changed;

    function automatic void chk(input string name, input logic [NSW-1:0] act, input logic [NSW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, req);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NSW; i++) begin
            pipe_q[i].delete();
            hist_q[i].delete();
            repeat (S) pipe_q[i].push_back(1'b0);
        end
        m_stable  = '0;
        m_rise    = '0;
        m_fall    = '0;
        m_changed = '0;
    endfunction

    function automatic void model_edge(input logic [NSW-1:0] raw, input logic [NSW-1:0] clr);
        bit s;
        bit all_diff;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < NSW; i++) begin
            s = pipe_q[i].pop_front();
            pipe_q[i].push_back(raw[i]);
            hist_q[i].push_back(s);
            if (hist_q[i].size() > D) void'(hist_q[i].pop_front());
            all_diff = (hist_q[i].size() == D);
            for (int j = 0; j < hist_q[i].size(); j++)
                if (hist_q[i][j] == m_stable[i]) all_diff = 1'b0;
            if (all_diff) begin
                m_stable[i]  = s;
                m_rise[i]    = EDGE_EN & s;
                m_fall[i]    = EDGE_EN & ~s;
                m_changed[i] = EDGE_EN;
            end else if (clr[i]) begin
                m_changed[i] = 1'b0;
            end
        end
    endfunction

    task automatic step(input logic [NSW-1:0] raw, input logic [NSW-1:0] clr, input logic rst_n);
        @(negedge clock);
        #1;
        sw_raw      = raw;
        clr_changed = clr;
        reset       = rst_n;
        if (!rst_n) begin
            model_reset();
            #1;
            chk("async_reset", sw_stable | sw_rise | sw_fall | sw_changed, '0);
        end
        @(posedge clock);
        if (rst_n) model_edge(raw, clr);
        exp_q.push_back('{m_stable, m_rise, m_fall, m_changed});
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("sw_stable",  sw_stable,  mon_e.stable);
            chk("sw_rise",    sw_rise,    mon_e.rise);
            chk("sw_fall",    sw_fall,    mon_e.fall);
            chk("sw_changed", sw_changed, mon_e.changed);
        end
    end

    initial begin
        logic [NSW-1:0] r;
        logic [NSW-1:0] c;
        logic           rn;
        int             hold[NSW];

        model_reset();
        repeat (3)  step(2'b11, 2'b00, 1'b0);
        repeat (25) step(2'b11, 2'b00, 1'b1);
        repeat (25) step(2'b00, 2'b00, 1'b1);

        for (int k = 0; k < 40; k++) step({1'b0, 1'((k / 5) % 2 == 0)}, 2'b00, 1'b1);
        repeat (25) step(2'b01, 2'b00, 1'b1);

        repeat (15) step(2'b11, 2'b00, 1'b1);
        repeat (25) step(2'b01, 2'b00, 1'b1);
        repeat (16) step(2'b11, 2'b00, 1'b1);
        repeat (30) step(2'b01, 2'b00, 1'b1);

        step(2'b01, 2'b01, 1'b1);
        repeat (3)  step(2'b01, 2'b00, 1'b1);
        repeat (17) step(2'b00, 2'b00, 1'b1);
        step(2'b00, 2'b01, 1'b1);
        repeat (5)  step(2'b00, 2'b00, 1'b1);

        repeat (10) step(2'b10, 2'b00, 1'b1);
        step(2'b10, 2'b00, 1'b0);
        repeat (25) step(2'b10, 2'b00, 1'b1);

        r = 2'b10;
        for (int i = 0; i < NSW; i++) hold[i] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NSW; i++) begin
                if (hold[i] == 0) begin
                    r[i]    = ~r[i];
                    hold[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(14, 18) : $urandom_range(1, 40);
                end
                hold[i]--;
            end
            c  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            rn = ($urandom_range(0, 499) != 0);
            step(r, c, rn);
        end

        @(negedge clock);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_switch_conditioner.md
# io_switch_conditioner

Input-conditioning stage directly upstream of the data-memory IO device. It takes the raw slide-switch inputs, synchronizes and debounces them, and drives the clean levels that the data-memory IO device presents to PMIPSL0 as switch 0 / switch 1. Optional edge pulses and sticky change flags let software poll for switch activity without sampling continuously.

## Interface
- `NUM_SW`, 2: number of switches conditioned.
- `SYNC_STAGES`, 2: synchronizer flip-flop depth, must be ≥2.
- `DEBOUNCE_CYCLES`, 16: consecutive mismatching cycles required to accept a new level, must be ≥2; counter width is clog2(DEBOUNCE_CYCLES).
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `sw_raw` in NUM_SW: raw asynchronous switch pins.
- `clr_changed` in NUM_SW: per-bit clear of `sw_changed`, from the IO device's write strobe.
- `sw_stable` out NUM_SW: debounced level, feeds io_sw0/io_sw1.
- `sw_rise` out NUM_SW: one-cycle pulse on accepted 0→1.
- `sw_fall` out NUM_SW: one-cycle pulse on accepted 1→0.
- `sw_changed` out NUM_SW: sticky flag, set on any accepted transition.

## Operation
- Per switch, fully independent, no shared state.
- `sw_raw[i]` passes through a SYNC_STAGES flop chain; the last stage is `synced[i]`.
- At each edge:
  - If `synced != sw_stable`:
    - If count == DEBOUNCE_CYCLES-1: `sw_stable <= synced`, count <= 0, and the matching rise/fall pulse is asserted for that one cycle.
    - Otherwise count increments.
  - If `synced == sw_stable`: count <= 0, so any bounce restarts the window.
- Counter saturation: it never exceeds DEBOUNCE_CYCLES-1; wrap is impossible by construction.
- `sw_changed[i]`:
  - Set on the same edge `sw_stable[i]` changes.
  - Cleared on the edge after `clr_changed[i]`=1.
  - Simultaneous set and clear: set wins and the flag stays 1.
- Reset (asynchronous assertion) drives all of the following to 0: sync flops, counters, `sw_stable`, `sw_rise`, `sw_fall`, `sw_changed`. Reset mid-count discards the partial count.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Latency: if the raw level is first captured at edge k and stays steady, `sw_stable` updates at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. That is 18 edges inclusive with the defaults.
- Rejection: a raw pulse of fewer than DEBOUNCE_CYCLES cycles is rejected. A pulse of DEBOUNCE_CYCLES or more cycles is accepted.
- `sw_rise`/`sw_fall` are high exactly one cycle, coincident with the `sw_stable` change.
- Reset release is synchronous to the design's reset tree. The first counting edge is the first edge after deassertion.

## Configuration
- `SWITCH_EDGE_EN` defined:
  - Rise/fall pulse registers and the `sw_changed` flags are compiled in as described above.
- `SWITCH_EDGE_EN` undefined:
  - `sw_rise`, `sw_fall` and `sw_changed` are tied to 0.
  - `clr_changed` is ignored.
  - Ports remain present.
  - `sw_stable` behaviour is identical in both builds.

## Structure
- Shared package `io_pkg`: the default constants for NUM_SW, SYNC_STAGES and DEBOUNCE_CYCLES, plus the debounce counter width derivation. The IO device reuses these.
- One sub-module, `sw_debounce_cell`, covers one switch: synchronizer, counter, stable register, edge/flag logic.
- The top instantiates NUM_SW cells in a generate loop.

## Test plan
- Reset release: hold `reset`=0 with `sw_raw`=2'b11, so all outputs read 0. Release, and `sw_stable`=2'b11 at the 18th edge. `sw_rise`=2'b11 for one cycle, then `sw_changed`=2'b11.
- Bounce: toggle `sw_raw[0]` every 5 cycles for 40 cycles, then hold 1. `sw_stable[0]` stays 0 throughout the bounce and rises 18 edges after the final raw edge. `sw_stable[1]` is unaffected.
- Glitch filter: a 15-cycle high pulse on `sw_raw[1]` causes no change and no pulse. A 16-cycle pulse makes `sw_stable[1]` rise and then fall 16 cycles later, with one `sw_rise` and one `sw_fall` pulse.
- Flag clear: with `sw_changed[0]`=1, assert `clr_changed[0]` alone, and the flag reads 0 next cycle. Assert clear on the same edge as a new transition, and the flag stays 1.
- Reset mid-operation: after 10 mismatch cycles, pulse `reset` low for 1 cycle. All outputs and counters return to 0 immediately, and the full 18-edge latency restarts.
- `SWITCH_EDGE_EN` undefined: rerun the reset-release scenario. `sw_stable` timing is identical, and `sw_rise`/`sw_fall`/`sw_changed` stay 0.
